// File: rtl/fetch_stage.sv
// Instruction fetch stage of the five-stage RV64 pipeline.
// Owns the PC and issues one request at a time on the instruction bus. It also drives the
// fetch->decode pipeline register, holds it while decode stalls, and flushes it on a redirect.
// Responses that belong to a wrong-path request are dropped.
//
// Ports:
//   clk, resetn         clock; asynchronous active-low reset
//   ireq_valid/addr     instruction request; held stable until iresp_data_ok
//   iresp_data_ok/data  response for the outstanding request
//   stallF              decode stall; the fetch->decode register holds
//   redirect_valid/pc   one-cycle control-flow redirect and its target
//   instrF_valid/raw    fetch->decode register: valid flag and instruction word
//   pcF                 fetch->decode register: PC of instrF_raw
module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instrF_valid,
  output logic [31:0] instrF_raw,
  output logic [63:0] pcF
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StKill} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] target_q, target_d;
  logic [31:0] buf_q, buf_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_raw_q, out_raw_d;
  logic [63:0] out_pc_q, out_pc_d;

  logic        deliver;
  logic [31:0] deliver_raw;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    buf_d       = buf_q;
    deliver     = 1'b0;
    deliver_raw = buf_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect_valid && iresp_data_ok) begin
          // The response is for the wrong path. Drop it and request the target next cycle.
          pc_d = redirect_pc;
        end else if (redirect_valid) begin
          // The request must complete at its old address before the target can be fetched.
          target_d = redirect_pc;
          state_d  = StKill;
        end else if (iresp_data_ok && !stallF) begin
          deliver     = 1'b1;
          deliver_raw = iresp_data;
          pc_d        = pc_q + 64'd4;
        end else if (iresp_data_ok) begin
          buf_d   = iresp_data;
          state_d = StHold;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (!stallF) begin
          deliver     = 1'b1;
          deliver_raw = buf_q;
          pc_d        = pc_q + 64'd4;
          state_d     = StReq;
        end
      end
      StKill: begin
        if (redirect_valid) begin
          target_d = redirect_pc;
        end
        if (iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : target_q;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A redirect flushes the register even while decode stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_raw_d   = out_raw_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (!stallF) begin
      if (deliver) begin
        out_valid_d = 1'b1;
        out_raw_d   = deliver_raw;
        out_pc_d    = pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pc_q        <= PC_RESET;
      target_q    <= 64'd0;
      buf_q       <= 32'd0;
      out_valid_q <= 1'b0;
      out_raw_q   <= 32'd0;
      out_pc_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_raw_q   <= out_raw_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign ireq_valid   = (state_q == StReq) || (state_q == StKill);
  assign ireq_addr    = pc_q;
  assign instrF_valid = out_valid_q;
  assign instrF_raw   = out_raw_q;
  assign pcF          = out_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [63:0] PcReset = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stallF;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instrF_valid;
  logic [31:0] instrF_raw;
  logic [63:0] pcF;

  int checks = 0;
  int errors = 0;

  // Reference model of the fetch stage's behaviour.
  bit          m_idle, m_hold, m_kill;
  logic [63:0] m_pc, m_target, m_opc;
  logic [31:0] m_buf, m_oraw;
  bit          m_ov;

  fetch_stage #(.PC_RESET(PcReset)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stallF        (stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instrF_valid  (instrF_valid),
    .instrF_raw    (instrF_raw),
    .pcF           (pcF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_hold = 0; m_kill = 0;
    m_pc = PcReset; m_target = 64'd0; m_buf = 32'd0;
    m_ov = 0; m_oraw = 32'd0; m_opc = 64'd0;
  endtask

  task automatic check_model();
    check("ireq_valid", {63'd0, ireq_valid}, {63'd0, !m_idle && !m_hold});
    check("ireq_addr", ireq_addr, m_pc);
    check("instrF_valid", {63'd0, instrF_valid}, {63'd0, m_ov});
    check("instrF_raw", {32'd0, instrF_raw}, {32'd0, m_oraw});
    check("pcF", pcF, m_opc);
  endtask

  // The model's view of one clock edge, given the inputs that were held over the cycle.
  task automatic model_update(input bit rv, input logic [63:0] rpc, input bit ok,
                              input logic [31:0] data, input bit st);
    bit          got;
    logic [31:0] word;
    logic [63:0] at;
    got = 0; word = 32'd0; at = m_pc;
    if (m_idle) begin
      m_idle = 0;
    end else if (m_hold) begin
      if (rv) begin
        m_pc = rpc; m_hold = 0;
      end else if (!st) begin
        got = 1; word = m_buf; m_pc = m_pc + 64'd4; m_hold = 0;
      end
    end else if (m_kill) begin
      if (rv) m_target = rpc;
      if (ok) begin
        m_pc = m_target; m_kill = 0;
      end
    end else begin
      if (rv && ok) m_pc = rpc;
      else if (rv) begin
        m_target = rpc; m_kill = 1;
      end else if (ok && !st) begin
        got = 1; word = data; m_pc = m_pc + 64'd4;
      end else if (ok) begin
        m_buf = data; m_hold = 1;
      end
    end
    if (rv) m_ov = 0;
    else if (!st) begin
      if (got) begin
        m_ov = 1; m_oraw = word; m_opc = at;
      end else m_ov = 0;
    end
  endtask

  // Called just after a rising edge. It checks the outputs against the model, applies the
  // inputs for the coming cycle, and advances the model on the next edge.
  task automatic step(input bit rv, input logic [63:0] rpc, input bit ok,
                      input logic [31:0] data, input bit st);
    check_model();
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data_ok  = ok;
    iresp_data     = data;
    stallF         = st;
    @(posedge clk);
    #1;
    model_update(rv, rpc, ok, data, st);
  endtask

  initial begin
    resetn = 1'b1;
    iresp_data_ok = 1'b0; iresp_data = 32'd0; stallF = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'd0;
    model_reset();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model();
    resetn = 1'b1;

    // Reset release and streaming.
    step(0, 64'd0, 1, 32'h0000_0013, 0);              // IDLE
    check("first_addr", ireq_addr, 64'h8000_0000);
    step(0, 64'd0, 1, 32'h0000_0013, 0);
    check("stream_pcF", pcF, 64'h8000_0000);
    check("stream_addr", ireq_addr, 64'h8000_0004);

    // Stall with data.
    step(0, 64'd0, 1, 32'h00A0_0093, 1);
    step(0, 64'd0, 0, 32'd0, 1);
    check("hold_no_req", {63'd0, ireq_valid}, 64'd0);
    check("hold_pcF", pcF, 64'h8000_0000);
    step(0, 64'd0, 0, 32'd0, 1);
    step(0, 64'd0, 0, 32'd0, 0);
    check("release_raw", {32'd0, instrF_raw}, 64'h0000_0000_00A0_0093);
    check("release_pcF", pcF, 64'h8000_0004);
    check("release_addr", ireq_addr, 64'h8000_0008);

    // Redirect during a slow request.
    step(0, 64'd0, 0, 32'd0, 0);
    step(1, 64'h8000_0100, 0, 32'd0, 0);
    step(0, 64'd0, 0, 32'd0, 0);
    check("kill_addr", ireq_addr, 64'h8000_0008);
    step(0, 64'd0, 1, 32'hDEAD_BEEF, 0);
    check("kill_flushed", {63'd0, instrF_valid}, 64'd0);
    check("kill_new_addr", ireq_addr, 64'h8000_0100);

    // Double redirect in KILL.
    step(1, 64'h8000_0100, 0, 32'd0, 0);
    step(1, 64'h8000_0200, 0, 32'd0, 0);
    step(0, 64'd0, 1, 32'h1234_5678, 0);
    check("double_addr", ireq_addr, 64'h8000_0200);

    // Redirect arriving with the response while decode stalls.
    step(0, 64'd0, 1, 32'h0000_0013, 0);
    step(1, 64'h8000_0300, 1, 32'hCAFE_F00D, 1);
    check("simul_flush", {63'd0, instrF_valid}, 64'd0);
    check("simul_addr", ireq_addr, 64'h8000_0300);

    // The PC wraps past the top of the address space.
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'd0, 0);
    step(0, 64'd0, 1, 32'h0000_0067, 0);
    check("wrap_addr", ireq_addr, 64'd0);
    check("wrap_pcF", pcF, 64'hFFFF_FFFF_FFFF_FFFC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit          rv, ok, st;
      logic [63:0] rpc;
      rv  = ($urandom_range(7) == 0);
      ok  = ($urandom_range(1) == 1);
      st  = ($urandom_range(2) == 0);
      rpc = ($urandom_range(15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      step(rv, rpc, ok, $urandom, st);
    end

    // Asynchronous reset while in KILL.
    step(1, 64'h8000_0500, 1, 32'd0, 0);
    step(0, 64'd0, 1, 32'h0000_0093, 0);
    step(1, 64'h8000_0600, 0, 32'd0, 0);
    check_model();
    #2 resetn = 1'b0;
    #1;
    check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("rst_instrF_valid", {63'd0, instrF_valid}, 64'd0);
    check("rst_pcF", pcF, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(0, 64'd0, 1, 32'h0000_0013, 0);
    check("restart_addr", ireq_addr, PcReset);
    step(0, 64'd0, 1, 32'h0000_0013, 0);
    step(0, 64'd0, 0, 32'd0, 0);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
